// File: rtl/tx_core_pkg.sv
// Shared types and line constants for the UART transmit serializer.
// The optional parity stage is controlled by the TX_CORE_PARITY_EN macro.
package tx_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/tx_baud_tick.sv
// Baud divider for tx_core: counts CLKS_PER_BIT cycles per serial bit and
// flags the last cycle of each bit with a one-cycle tick.
module tx_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic tx_clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // With CLKS_PER_BIT=1 the count never leaves zero and every enabled cycle ticks.
  always_ff @(posedge tx_clk) begin
    if (reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tx_core.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity
// (TX_CORE_PARITY_EN), STOP_BITS stop bits. Reset input is active high.
module tx_core
  import tx_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 tx_clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic                 accept;
  logic                 bit_tick;
`ifdef TX_CORE_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = (state == IDLE) && tx_valid && tx_ready;

  tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .tx_clk (tx_clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (state != IDLE),
    .tick   (bit_tick)
  );

  // Each state presets tx for the next bit at the tick ending the current one,
  // so the line level is always a register.
  always_ff @(posedge tx_clk) begin
    if (reset_n) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
`ifdef TX_CORE_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          if (accept) begin
            shreg    <= tx_data;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_ready <= 1'b0;
            tx       <= START_LEVEL;
            state    <= START;
`ifdef TX_CORE_PARITY_EN
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef TX_CORE_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= IDLE_LEVEL;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef TX_CORE_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            tx    <= IDLE_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (stop_idx == LAST_STOP) begin
              tx       <= IDLE_LEVEL;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          tx       <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_core.sv
// Scoreboard bench for tx_core: one instance at CLKS_PER_BIT=1/STOP_BITS=1 and
// one at CLKS_PER_BIT=4/STOP_BITS=2, with a line monitor decoding each frame.
module tb_tx_core;

`ifdef TX_CORE_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset1, valid1, ready1, done1, line1;
  logic       reset4, valid4, ready4, done4, line4;
  logic [7:0] data1, data4;
  logic [7:0] q1[$];
  logic [7:0] q4[$];
  logic       pd1 = 1'b0, pd4 = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  tx_core #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .tx_clk(clk), .reset_n(reset1), .tx_valid(valid1), .tx_data(data1),
    .tx_ready(ready1), .tx_done(done1), .tx(line1)
  );

  tx_core #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) dut4 (
    .tx_clk(clk), .reset_n(reset4), .tx_valid(valid4), .tx_data(data4),
    .tx_ready(ready4), .tx_done(done4), .tx(line4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic getTx(input int w);    return w != 0 ? line4  : line1;  endfunction
  function automatic logic getReady(input int w); return w != 0 ? ready4 : ready1; endfunction
  function automatic logic getDone(input int w);  return w != 0 ? done4  : done1;  endfunction
  function automatic logic getRst(input int w);   return w != 0 ? reset4 : reset1; endfunction

  // Expected line level for bit position pos of a frame carrying byte b.
  function automatic logic lineBit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef TX_CORE_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at the first negedge showing the start bit; follows the whole frame.
  task automatic monitorFrame(input int w, input int cpb, input int sb);
    int         len, bad, readyBad, doneBad;
    logic [7:0] exp, got;
    bit         aborted;
    string      pfx;
    pfx = $sformatf("c%0d", cpb);
    len = (1 + 8 + PBITS + sb) * cpb;
    bad = 0; readyBad = 0; doneBad = 0; got = 8'h00; aborted = 0;
    if (w != 0 ? q4.size() == 0 : q1.size() == 0) begin
      checkOutput({pfx, "_unexpected_frame"}, 1, 0);
      exp = 8'h00;
    end else begin
      exp = (w != 0) ? q4.pop_front() : q1.pop_front();
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (getRst(w) === 1'b1) begin
        aborted = 1;
        break;
      end
      if (getTx(w) !== lineBit(exp, c / cpb)) bad++;
      if (getReady(w) !== 1'b0) readyBad++;
      if (getDone(w) !== 1'b0) doneBad++;
      if ((c % cpb) == (cpb / 2) && (c / cpb) >= 1 && (c / cpb) <= 8) got[c/cpb-1] = getTx(w);
    end
    if (!aborted) begin
      @(negedge clk);
      checkOutput({pfx, "_frame_shape"}, bad, 0);
      checkOutput({pfx, "_ready_low"}, readyBad, 0);
      checkOutput({pfx, "_done_early"}, doneBad, 0);
      checkOutput({pfx, "_rx_byte"}, got, exp);
      checkOutput({pfx, "_done_pulse"}, getDone(w), 1);
      checkOutput({pfx, "_ready_back"}, getReady(w), 1);
      checkOutput({pfx, "_idle_line"}, getTx(w), 1);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset1 === 1'b0 && line1 === 1'b0) monitorFrame(0, 1, 1);
  end

  initial forever begin
    @(negedge clk);
    if (reset4 === 1'b0 && line4 === 1'b0) monitorFrame(1, 4, 2);
  end

  // tx_done must never stay high for two consecutive cycles.
  always @(negedge clk) begin
    if (done1 === 1'b1 && pd1 === 1'b1) checkOutput("c1_done_width", 2, 1);
    if (done4 === 1'b1 && pd4 === 1'b1) checkOutput("c4_done_width", 2, 1);
    pd1 <= done1;
    pd4 <= done4;
  end

  // Raises tx_valid with byte b, waits for the accept edge and scoreboards it.
  task automatic applyStimulus(input int w, input logic [7:0] b, output time acceptTime);
    int waitCnt;
    waitCnt = 0;
    acceptTime = 0;
    if (w != 0) begin valid4 = 1'b1; data4 = b; end
    else begin valid1 = 1'b1; data1 = b; end
    while (getReady(w) !== 1'b1 && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 500) begin
      checkOutput("accept_timeout", 1, 0);
      return;
    end
    @(posedge clk);
    acceptTime = $time;
    if (w != 0) q4.push_back(b);
    else q1.push_back(b);
    #1;
  endtask

  task automatic waitIdle(input int w);
    int n;
    n = 0;
    while (((w != 0 ? q4.size() : q1.size()) != 0 || getReady(w) !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    time t, prevT;
    int  deviations;
    int  doneSeen;
    reset1 = 1'b1; reset4 = 1'b1;
    valid1 = 1'b0; valid4 = 1'b0;
    data1 = 8'h00; data4 = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx1", line1, 1);
    checkOutput("rst_ready1", ready1, 1);
    checkOutput("rst_done1", done1, 0);
    checkOutput("rst_tx4", line4, 1);
    checkOutput("rst_ready4", ready4, 1);
    checkOutput("rst_done4", done4, 0);
    reset1 = 1'b0; reset4 = 1'b0;
    deviations = 0;
    repeat (20) begin
      @(negedge clk);
      if (line1 !== 1'b1 || ready1 !== 1'b1 || done1 !== 1'b0) deviations++;
      if (line4 !== 1'b1 || ready4 !== 1'b1 || done4 !== 1'b0) deviations++;
    end
    checkOutput("idle_hold", deviations, 0);

    $display("[TB] single byte 0xA5 at one clock per bit");
    applyStimulus(0, 8'hA5, t);
    valid1 = 1'b0;
    waitIdle(0);

    $display("[TB] 100 back-to-back random bytes");
    prevT = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 8'($urandom), t);
      if (i > 0) checkOutput("c1_spacing", 32'((t - prevT) / 10), 11);
      prevT = t;
    end
    valid1 = 1'b0;
    waitIdle(0);

    $display("[TB] 0x01 at four clocks per bit, two stop bits");
    applyStimulus(1, 8'h01, t);
    valid4 = 1'b0;
    waitIdle(1);
    applyStimulus(1, 8'hC6, t);
    applyStimulus(1, 8'h5B, prevT);
    checkOutput("c4_spacing", 32'((prevT - t) / 10), 4 * (11 + PBITS) + 1);
    valid4 = 1'b0;
    waitIdle(1);

    $display("[TB] reset during bit 3");
    applyStimulus(0, 8'h96, t);
    valid1 = 1'b0;
    repeat (5) @(negedge clk);
    reset1 = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", line1, 1);
    checkOutput("abort_ready", ready1, 1);
    checkOutput("abort_done", done1, 0);
    reset1 = 1'b0;
    doneSeen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done1 !== 1'b0 || line1 !== 1'b1) doneSeen++;
    end
    checkOutput("abort_quiet", doneSeen, 0);
    applyStimulus(0, 8'h3C, t);
    valid1 = 1'b0;
    waitIdle(0);

`ifdef TX_CORE_PARITY_EN
    $display("[TB] parity bytes 0x07 and 0x03");
    applyStimulus(0, 8'h07, t);
    applyStimulus(0, 8'h03, t);
    valid1 = 1'b0;
    waitIdle(0);
`endif

    checkOutput("q1_empty", q1.size(), 0);
    checkOutput("q4_empty", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
